// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - runtime-configurable UART transmitter fed from a latency-1 FIFO
//
// Purpose:
//   Pulls one word per frame from a FIFO (empty/re handshake, din valid the
//   cycle after re). It transmits the word as start bit, N data bits LSB-first,
//   optional parity and one or two stop bits. The divisor, word width, parity and
//   stop count are sampled once per frame in LOAD. A line break (dout=0) can be
//   requested whenever the engine is idle.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   din            FIFO read data, valid the cycle after re
//   empty          FIFO empty flag
//   re             FIFO read enable, one-cycle pulse per frame
//   dout           serial line, idle/mark = 1
//   cfg_divisor    clk cycles per bit, 0 selects CLOCK_FREQUENCY/BAUD_RATE
//   cfg_word_width data bits per frame, clamped to [5, MAX_WORD_WIDTH]
//   cfg_parity     00 none, 01 odd, 10 even, 11 none
//   cfg_stop2      0: one stop bit, 1: two stop bits
//   cfg_break      request line break while idle
//   busy           high whenever the engine is not idle
//   tx_done        one-cycle pulse on the first idle cycle after a frame

module uart_tx_engine #(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned MAX_WORD_WIDTH  = 32'd9,
  parameter int unsigned DIV_WIDTH       = 32'd16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAX_WORD_WIDTH-1:0] din,
  input  logic                      empty,
  output logic                      re,
  output logic                      dout,
  input  logic [DIV_WIDTH-1:0]      cfg_divisor,
  input  logic [3:0]                cfg_word_width,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stop2,
  input  logic                      cfg_break,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int unsigned          LP_DEF_DIV_INT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [DIV_WIDTH-1:0] LP_DEFAULT_DIV = LP_DEF_DIV_INT[DIV_WIDTH-1:0];
  localparam logic [DIV_WIDTH-1:0] LP_MIN_DIV     = {{(DIV_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [DIV_WIDTH-1:0] LP_ONE         = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]           LP_MAX_N       = MAX_WORD_WIDTH[3:0];
  localparam logic [3:0]           LP_MIN_N       = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6,
    S_BREAK  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Per-frame latched configuration
  logic [DIV_WIDTH-1:0]      r_div_last;   // D-1, terminal value of the cycle counter
  logic [3:0]                r_n_last;     // N-1, index of the last data bit
  logic                      r_par_en;
  logic                      r_par_bit;
  logic                      r_stop2;

  // Frame progress
  logic [DIV_WIDTH-1:0]      r_cyc;
  logic [3:0]                r_bit_idx;
  logic                      r_stop_idx;
  logic [MAX_WORD_WIDTH-1:0] r_shift;
  logic                      r_tx_done;

  // Effective configuration, only consumed in LOAD
  logic [DIV_WIDTH-1:0]      w_div_sel;
  logic [DIV_WIDTH-1:0]      w_div;
  logic [3:0]                w_n;
  logic                      w_xor;

  logic                      w_bit_end;
  logic                      w_data_end;
  logic                      w_stop_end;

  always_comb begin
    w_div_sel = (cfg_divisor == '0) ? LP_DEFAULT_DIV : cfg_divisor;
    w_div     = (w_div_sel < LP_MIN_DIV) ? LP_MIN_DIV : w_div_sel;

    if (cfg_word_width < LP_MIN_N) begin
      w_n = LP_MIN_N;
    end else if (cfg_word_width > LP_MAX_N) begin
      w_n = LP_MAX_N;
    end else begin
      w_n = cfg_word_width;
    end

    // Only the bits actually transmitted contribute to parity
    w_xor = 1'b0;
    for (int i = 0; i < int'(MAX_WORD_WIDTH); i++) begin
      if (i < int'(w_n)) begin
        w_xor = w_xor ^ din[i];
      end
    end
  end

  assign w_bit_end  = (r_cyc == r_div_last);
  assign w_data_end = w_bit_end && (r_bit_idx == r_n_last);
  assign w_stop_end = w_bit_end && (r_stop_idx == r_stop2);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_break) begin
          w_next_state = S_BREAK;
        end else if (!empty) begin
          w_next_state = S_READ;
        end
      end
      S_READ:   w_next_state = S_LOAD;
      S_LOAD:   w_next_state = S_START;
      S_START:  if (w_bit_end) w_next_state = S_DATA;
      S_DATA:   if (w_data_end) w_next_state = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next_state = S_STOP;
      S_STOP:   if (w_stop_end) w_next_state = S_IDLE;
      S_BREAK:  if (!cfg_break) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    re      = (r_state == S_READ);
    busy    = (r_state != S_IDLE);
    tx_done = r_tx_done;
    case (r_state)
      S_START:  dout = 1'b0;
      S_DATA:   dout = r_shift[0];
      S_PARITY: dout = r_par_bit;
      S_BREAK:  dout = 1'b0;
      default:  dout = 1'b1;
    endcase
  end

  // Datapath: config latch, shifter and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_last <= '0;
      r_n_last   <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_cyc      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= (r_state == S_STOP) && w_stop_end;

      case (r_state)
        S_LOAD: begin
          r_shift    <= din;
          r_div_last <= w_div - LP_ONE;
          r_n_last   <= w_n - 4'd1;
          r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          r_par_bit  <= (cfg_parity == 2'b01) ? ~w_xor : w_xor;
          r_stop2    <= cfg_stop2;
          r_cyc      <= '0;
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
        end
        S_START, S_PARITY: begin
          r_cyc <= w_bit_end ? '0 : r_cyc + LP_ONE;
        end
        S_DATA: begin
          r_cyc <= w_bit_end ? '0 : r_cyc + LP_ONE;
          if (w_bit_end) begin
            r_shift   <= {1'b1, r_shift[MAX_WORD_WIDTH-1:1]};
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        S_STOP: begin
          r_cyc <= w_bit_end ? '0 : r_cyc + LP_ONE;
          if (w_bit_end) begin
            r_stop_idx <= ~r_stop_idx;
          end
        end
        default: begin
          r_cyc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine

module tb_uart_tx_engine;

  logic       clk;
  logic       rst;
  logic [8:0] din;
  logic       empty;
  logic       re;
  logic       dout;
  logic [15:0] cfg_divisor;
  logic [3:0] cfg_word_width;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       cfg_break;
  logic       busy;
  logic       tx_done;

  int tests;
  int fails;

  // FIFO model: latency-1 read, pointers owned by one process each
  logic [8:0] mem [0:15];
  int wr_ptr;
  int rd_ptr;
  int re_count;

  assign empty = (wr_ptr == rd_ptr);

  uart_tx_engine #(
    .CLOCK_FREQUENCY(32'd100_000_000),
    .BAUD_RATE      (32'd115200),
    .MAX_WORD_WIDTH (32'd9),
    .DIV_WIDTH      (32'd16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .empty         (empty),
    .re            (re),
    .dout          (dout),
    .cfg_divisor   (cfg_divisor),
    .cfg_word_width(cfg_word_width),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .cfg_break     (cfg_break),
    .busy          (busy),
    .tx_done       (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rd_ptr   = 0;
    re_count = 0;
    din      = '0;
  end

  always @(negedge clk) begin
    if (re === 1'b1) begin
      din      = mem[rd_ptr[3:0]];
      rd_ptr   = rd_ptr + 1;
      re_count = re_count + 1;
    end
  end

  task automatic push(input logic [8:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic set_cfg(input logic [15:0] dv, input logic [3:0] ww,
                         input logic [1:0] par, input logic s2);
    cfg_divisor    = dv;
    cfg_word_width = ww;
    cfg_parity     = par;
    cfg_stop2      = s2;
  endtask

  // Called at a negedge. exp[b] is the b-th bit on the line (start first).
  task automatic check_frame(input string name, input logic [31:0] exp,
                             input int nbits, input int d);
    int   n;
    logic bad;
    logic act;
    logic early;
    n = 0;
    while (dout !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (dout !== 1'b0) begin
      fails++;
      $display("FAIL %s start: dout=%b after %0d cycles, required 0", name, dout, n);
      return;
    end
    early = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      bad = 1'b0;
      act = exp[b];
      for (int c = 0; c < d; c++) begin
        if (dout !== exp[b] && !bad) begin
          bad = 1'b1;
          act = dout;
        end
        if (tx_done !== 1'b0) early = 1'b1;
        @(negedge clk);
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s bit%0d: dout=%b, required %b", name, b, act, exp[b]);
      end
    end
    tests++;
    if (tx_done !== 1'b1) begin
      fails++;
      $display("FAIL %s tx_done: got %b after %0d clk, required 1", name, tx_done, nbits * d);
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL %s tx_done_early: pulsed inside frame, required 0", name);
    end
  endtask

  task automatic test_reset;
    tests++;
    if (dout !== 1'b1) begin fails++; $display("FAIL reset_dout: got %b, required 1", dout); end
    tests++;
    if (re !== 1'b0) begin fails++; $display("FAIL reset_re: got %b, required 0", re); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++;
    if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_tx_done: got %b, required 0", tx_done); end
  endtask

  task automatic test_8n1;
    int rc0;
    rc0 = re_count;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    push(9'h055);
    check_frame("8n1_55", {22'b0, 1'b1, 8'h55, 1'b0}, 10, 4);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL 8n1_busy_after: got %b, required 0", busy); end
    tests++;
    if (re_count - rc0 != 1) begin
      fails++; $display("FAIL 8n1_re_count: got %0d, required 1", re_count - rc0);
    end
  endtask

  task automatic test_parity_7bit;
    set_cfg(16'd3, 4'd7, 2'b10, 1'b1);
    push(9'h041);
    check_frame("7e2_41", {21'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, 3);
    set_cfg(16'd3, 4'd7, 2'b01, 1'b1);
    push(9'h041);
    check_frame("7o2_41", {21'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11, 3);
  endtask

  task automatic test_width_clamp;
    set_cfg(16'd2, 4'd9, 2'b01, 1'b0);
    push(9'h1FF);
    check_frame("9o1_1ff", {20'b0, 1'b1, 1'b0, 9'h1FF, 1'b0}, 12, 2);
    set_cfg(16'd2, 4'd12, 2'b01, 1'b0);
    push(9'h1FF);
    check_frame("w12_clamp9", {20'b0, 1'b1, 1'b0, 9'h1FF, 1'b0}, 12, 2);
    set_cfg(16'd2, 4'd3, 2'b00, 1'b0);
    push(9'h09F);
    check_frame("w3_clamp5", {25'b0, 1'b1, 5'h1F, 1'b0}, 7, 2);
    // Upper bits 5..7 set: they must not affect even parity of 5'b00011
    set_cfg(16'd2, 4'd5, 2'b10, 1'b0);
    push(9'h0E3);
    check_frame("5e1_mask", {24'b0, 1'b1, 1'b0, 5'h03, 1'b0}, 8, 2);
  endtask

  task automatic test_back_to_back;
    int rc0;
    int m;
    rc0 = re_count;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    push(9'h0A5);
    push(9'h03C);
    check_frame("b2b_a5", {22'b0, 1'b1, 8'hA5, 1'b0}, 10, 4);
    m = 0;
    while (dout === 1'b1 && m < 20) begin
      m++;
      @(negedge clk);
    end
    tests++;
    if (m != 3) begin fails++; $display("FAIL b2b_gap: got %0d mark cycles, required 3", m); end
    check_frame("b2b_3c", {22'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    repeat (30) @(negedge clk);
    tests++;
    if (re_count - rc0 != 2) begin
      fails++; $display("FAIL b2b_re_count: got %0d, required 2", re_count - rc0);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_divisor;
    set_cfg(16'd0, 4'd8, 2'b00, 1'b0);
    push(9'h00F);
    check_frame("div0_868", {22'b0, 1'b1, 8'h0F, 1'b0}, 10, 868);
    set_cfg(16'd1, 4'd8, 2'b00, 1'b0);
    push(9'h0C3);
    check_frame("div1_clamp2", {22'b0, 1'b1, 8'hC3, 1'b0}, 10, 2);
  endtask

  task automatic test_reset_mid;
    int   n;
    logic seen;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    push(9'h000);
    n = 0;
    while (dout !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);  // inside the data bits, line low
    rst = 1'b1;
    #1;
    tests++;
    if (dout !== 1'b1) begin fails++; $display("FAIL rstmid_dout: got %b, required 1", dout); end
    tests++;
    if (re !== 1'b0) begin fails++; $display("FAIL rstmid_re: got %b, required 0", re); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || dout !== 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL rstmid_resume: line activity after reset, required none"); end
  endtask

  task automatic test_break;
    int rc0;
    rc0 = re_count;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    cfg_break = 1'b1;
    push(9'h096);
    repeat (5) @(negedge clk);
    tests++;
    if (dout !== 1'b0) begin fails++; $display("FAIL break_dout: got %b, required 0", dout); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b, required 1", busy); end
    tests++;
    if (re_count != rc0) begin fails++; $display("FAIL break_re: got %0d reads, required 0", re_count - rc0); end
    cfg_break = 1'b0;
    @(negedge clk);
    check_frame("after_break_96", {22'b0, 1'b1, 8'h96, 1'b0}, 10, 4);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    wr_ptr    = 0;
    rst       = 1'b1;
    cfg_break = 1'b0;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_8n1();
    test_parity_7bit();
    test_width_clamp();
    test_back_to_back();
    test_divisor();
    test_reset_mid();
    test_break();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised, runtime-configurable UART transmitter. It drains a show-ahead-free FIFO (read latency 1) through an empty/re handshake and serialises each word LSB-first. Word width, parity, stop-bit count and baud divisor are configurable per frame, and the block can force a line break. It supersedes the fixed 8N1 transmitter controller and sits between the TX FIFO and the board TX pin.

Parameters:
CLOCK_FREQUENCY, 32'd100_000_000, system clock in Hz
BAUD_RATE, 32'd115200, baud rate used when cfg_divisor==0
MAX_WORD_WIDTH, 32'd9, width of din; max data bits per frame (>=5)
DIV_WIDTH, 32'd16, width of cfg_divisor

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
din  input  MAX_WORD_WIDTH  FIFO read data, valid the cycle after re
empty  input  1  FIFO empty flag
re  output  1  FIFO read enable, one-cycle pulse per frame
dout  output  1  serial line, idle/mark = 1
cfg_divisor  input  DIV_WIDTH  clk cycles per bit; 0 selects DEFAULT_DIV = CLOCK_FREQUENCY/BAUD_RATE
cfg_word_width  input  4  data bits per frame
cfg_parity  input  2  00 none, 01 odd, 10 even, 11 treated as none
cfg_stop2  input  1  0: one stop bit, 1: two stop bits
cfg_break  input  1  request line break (dout=0)
busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes

Behaviour:
- Reset (async, immediate): state IDLE, dout=1, re=0, busy=0, tx_done=0, counters 0, shift register all ones. Reset mid-frame aborts the frame; the word is lost and there is no resume.
- All outputs are driven from registers or from a decode of registered state only, with no combinational path from inputs.
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP, BREAK.
- IDLE: if cfg_break=1 go to BREAK, which takes priority over !empty. Otherwise, if empty=0, go to READ with re<=1. Otherwise stay. dout=1.
- READ: re=1 for this cycle only; go to LOAD.
- LOAD: capture din into the shift register. Latch the effective config for the whole frame:
  - D = (cfg_divisor==0 ? DEFAULT_DIV : cfg_divisor), clamped to a minimum of 2.
  - N = cfg_word_width clamped to [5, MAX_WORD_WIDTH].
  - P = parity mode; S = 1 + cfg_stop2.
  - Parity bit: even = XOR of din[N-1:0]; odd = its inverse. Bits above N-1 are ignored.
  - Then go to START.
- START: dout=0 for D cycles, then DATA.
- DATA: dout = shift[0]. Every D cycles, shift right with 1 fill and increment the bit counter. After bit N-1 completes, go to PARITY if P is odd or even, else STOP.
- PARITY: dout = parity bit for D cycles, then STOP.
- STOP: dout=1 for S*D cycles. On the last cycle, tx_done<=1 (high the first IDLE cycle) and go to IDLE.
- BREAK: dout=0. Exit to IDLE on the first cycle cfg_break=0. No FIFO read occurs during break. cfg_break asserted mid-frame is ignored until IDLE.
- Config changes mid-frame have no effect on the current frame.
- Frame length in clk = D*(1+N+(P?1:0)+S).
- Back-to-back: with empty=0 continuously, there are exactly 3 mark cycles between frames (IDLE, READ, LOAD) plus stop bits. Exactly one re per frame.
- Bit-cycle counter width is DIV_WIDTH; the counter wraps to 0 at D-1 with no overflow.
- empty rising during READ/LOAD is not a concern: re was already issued while empty=0.

Test Plan:
1. 8N1, cfg_divisor=4, FIFO holds 0x55 -> re pulse once; dout=0 for 4 clk, then bits 1,0,1,0,1,0,1,0 at 4 clk each, then 1 for 4 clk; tx_done pulses at clk 40 after frame start; busy low after.
2. 7E2, divisor 3, din=0x41 -> bits 1,0,0,0,0,0,1, parity 0, two stop bits; 33-clk frame. Repeat as 7O2 -> parity bit 1.
3. 9-bit odd parity, divisor 2, din=9'h1FF -> nine 1 bits, parity 0 (nine ones is odd, so the odd-parity bit is 0); 24-clk frame. cfg_word_width=12 clamps to 9; =3 clamps to 5 (din=0x1F gives five 1 bits).
4. Back-to-back: FIFO holds 0xA5, 0x3C, 8N1, divisor 4 -> two re pulses; exactly 3 mark cycles between the first stop bit's end and the second start bit; empty stays high afterwards -> no further re.
5. cfg_divisor=0 with defaults -> each bit is 868 clk. cfg_divisor=1 -> clamped to 2 clk per bit.
6. Reset and break: assert rst mid-DATA -> dout=1, re=0, busy=0 in the same cycle, with no tx_done. cfg_break=1 in IDLE with empty=0 -> dout=0, busy=1, no re. Release -> IDLE, then a normal frame is read.
